ace_instbuf: RTL and testbench
==============================

Name: ace_instbuf

Overview:
Parametrised instruction buffer between ace_fetch and ace_decode. It replaces the fixed 8-in/4-out buffer.
- Accepts up to FETCH_W instructions per cycle with a sparse valid mask and compacts them in order.
- Stores them in a circular queue of DEPTH entries.
- Presents up to DEC_W oldest instructions to decode, which consumes a variable count per cycle.
- Provides full/empty back-pressure and a flush for retire redirects.

Parameters:
FETCH_W, 8, instruction lanes from fetch per cycle; power of 2, at least 1.
DEC_W, 4, instruction lanes presented to decode per cycle; at least 1 and at most FETCH_W.
DEPTH, 16, queue entries; power of 2, at least 2*FETCH_W.

Ports:
clock  in  1  core clock; all state updates on the rising edge.
reset  in  1  asynchronous, active-high reset.
flush_i  in  1  retire_flush; discards all entries.
fetch_inst_i  in  FETCH_W*32  fetched instructions; lane k occupies bits [32k+31:32k].
fetch_vld_i  in  FETCH_W  per-lane valid; any pattern is allowed, including non-contiguous.
deq_cnt_i  in  $clog2(DEC_W+1)  number of presented instructions decode consumes this cycle.
inst_o  out  DEC_W*32  oldest instructions; lane 0 is the oldest.
inst_vld_o  out  DEC_W  per-lane valid; always a thermometer code from lane 0.
count_o  out  $clog2(DEPTH)+1  number of occupied entries.
instbuf_full_o  out  1  high when free entries < FETCH_W; fetch must stall.
instbuf_empty_o  out  1  high when count is 0.

Behaviour:
Reset values:
- head, tail and count are 0; instbuf_empty_o = 1; instbuf_full_o = 0.
- inst_vld_o = 0; inst_o = 0.
Pointers:
- head and tail are $clog2(DEPTH) bits and wrap modulo DEPTH.
- count is tracked separately, so a full queue and an empty queue are unambiguous.
Enqueue:
- Accepted in a cycle when flush_i = 0, instbuf_full_o = 0 and |fetch_vld_i = 1.
- Valid lanes are compacted in ascending lane order and written to tail, tail+1, ...
- tail advances by popcount(fetch_vld_i).
- If instbuf_full_o = 1, input is dropped silently; fetch is responsible for holding it.
Present:
- inst_o and inst_vld_o are combinational from the registered entries at head..head+DEC_W-1.
- inst_vld_o[i] = (i < count).
- Invalid lanes drive inst_o = 0.
- Latency: an instruction enqueued in cycle N is visible at the outputs in cycle N+1. There is no bypass.
Dequeue:
- eff_deq = min(deq_cnt_i, number of valid presented lanes).
- head advances by eff_deq. Out-of-range requests are clamped, never underflow.
Simultaneous enqueue and dequeue:
- count_next = count + enq_cnt - eff_deq.
- instbuf_full_o is computed from the registered count only. Same-cycle dequeue does not relieve full.
- Because DEPTH >= 2*FETCH_W, an accepted enqueue can never overflow.
Flush:
- flush_i has priority over enqueue and dequeue in the same cycle.
- Next cycle: head = tail = count = 0; empty = 1; inst_vld_o = 0.
Wrap-around:
- Compaction writes and output reads index modulo DEPTH.
- One fetch group may straddle the entry DEPTH-1 to entry 0 boundary.
Reset mid-operation:
- Asserting reset forces the reset values immediately, without waiting for a clock edge.
- Entry storage is not reset; it is masked by count.

Optional Feature:
ACE_INSTBUF_PC_EN
- When defined, the block adds:
  - input fetch_pc_i, 64 bits: PC of fetch lane 0;
  - output pc_o, DEC_W*64.
- Each stored entry also holds PC = fetch_pc_i + 4*original_lane_index. The original lane index is taken before compaction.
- pc_o follows inst_o lane for lane and is 0 on invalid lanes.
- When undefined, these ports and the PC storage are absent and behaviour is otherwise identical.

Decomposition:
- ace_pkg holds:
  - ACE_INST_W = 32 and ACE_PC_W = 64;
  - a function for the instruction-buffer pointer width;
  - a popcount function.
- Sub-module ace_instbuf_compact:
  - combinational prefix-sum compaction of FETCH_W sparse lanes;
  - outputs the compacted instruction/PC vectors and the enqueue count.
- The queue, pointers and output muxing stay in ace_instbuf.

Test Plan:
All scenarios use FETCH_W = 8, DEC_W = 4, DEPTH = 16.
1. After reset, enqueue vld = 8'hFF with instructions 0..7, deq = 0 -> next cycle count = 8, inst_vld_o = 4'hF, inst_o = {3,2,1,0}, empty = 0, full = 0.
2. Sparse vld = 8'b1010_0101 with lane data k -> count = 4, inst_o lanes = {7,5,2,0}. With PC_EN and fetch_pc_i = 0x1000: pc_o = {0x101C, 0x1014, 0x1008, 0x1000}.
3. Fill to count = 9, then enqueue 8'hFF with deq = 4 in the same cycle -> enqueue dropped because full was registered high; count = 5 next cycle.
4. Wrap: put head = 12 and count = 0, then enqueue 8 -> entries 12..15 and 0..3 written; four dequeues of 2 return the instructions in original order; tail = 4.
5. count = 2 and deq_cnt_i = 4 -> eff_deq = 2; next cycle count = 0, empty = 1, inst_vld_o = 0.
6. count = 10, flush_i = 1 with simultaneous enqueue 8'hFF and deq = 3 -> next cycle count = 0, empty = 1, full = 0, nothing enqueued. Asserting reset mid-stream -> outputs return to reset values with no clock edge.

Source files
------------

// File: rtl/ace_pkg.sv
// Shared widths and helper functions for the ace front end.
// Used by ace_instbuf and ace_instbuf_compact.
package ace_pkg;

  localparam int ACE_INST_W = 32;
  localparam int ACE_PC_W   = 64;

  // Pointer width for a power-of-two instruction buffer; never narrower than one bit.
  function automatic int instbuf_ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int popcount(input logic [63:0] vec);
    int n;
    n = 0;
    for (int i = 0; i < 64; i++) begin
      n += int'(vec[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/ace_instbuf_compact.sv
// Packs the valid fetch lanes into ascending slots and reports how many there are.
// Optional PC tagging is enabled with `define ACE_INSTBUF_PC_EN.
module ace_instbuf_compact
  import ace_pkg::*;
#(
  parameter  int FETCH_W = 8,
  localparam int ENQ_W   = $clog2(FETCH_W + 1)
) (
  input  logic [FETCH_W*ACE_INST_W-1:0] fetch_inst_i,
  input  logic [FETCH_W-1:0]            fetch_vld_i,
`ifdef ACE_INSTBUF_PC_EN
  input  logic [ACE_PC_W-1:0]           fetch_pc_i,
  output logic [FETCH_W*ACE_PC_W-1:0]   cmp_pc_o,
`endif
  output logic [FETCH_W*ACE_INST_W-1:0] cmp_inst_o,
  output logic [ENQ_W-1:0]              enq_cnt_o
);

  // The running slot index is the prefix sum of the valid bits below each lane,
  // so lane k lands in slot popcount(fetch_vld_i[k-1:0]).
  always_comb begin
    int slot;
    cmp_inst_o = '0;
`ifdef ACE_INSTBUF_PC_EN
    cmp_pc_o   = '0;
`endif
    slot = 0;
    for (int k = 0; k < FETCH_W; k++) begin
      if (fetch_vld_i[k]) begin
        cmp_inst_o[slot*ACE_INST_W +: ACE_INST_W] = fetch_inst_i[k*ACE_INST_W +: ACE_INST_W];
`ifdef ACE_INSTBUF_PC_EN
        // PC comes from the lane position before compaction.
        cmp_pc_o[slot*ACE_PC_W +: ACE_PC_W] = fetch_pc_i + ACE_PC_W'(4 * k);
`endif
        slot++;
      end
    end
  end

  assign enq_cnt_o = ENQ_W'(popcount(64'(fetch_vld_i)));

endmodule

// File: rtl/ace_instbuf.sv
// Circular instruction buffer between fetch and decode with flush and back-pressure.
// Optional per-entry PC storage is enabled with `define ACE_INSTBUF_PC_EN.
module ace_instbuf
  import ace_pkg::*;
#(
  parameter int FETCH_W = 8,
  parameter int DEC_W   = 4,
  parameter int DEPTH   = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          flush_i,
  input  logic [FETCH_W*ACE_INST_W-1:0] fetch_inst_i,
  input  logic [FETCH_W-1:0]            fetch_vld_i,
  input  logic [$clog2(DEC_W+1)-1:0]    deq_cnt_i,
  output logic [DEC_W*ACE_INST_W-1:0]   inst_o,
  output logic [DEC_W-1:0]              inst_vld_o,
  output logic [$clog2(DEPTH):0]        count_o,
  output logic                          instbuf_full_o,
  output logic                          instbuf_empty_o
`ifdef ACE_INSTBUF_PC_EN
  ,
  input  logic [ACE_PC_W-1:0]           fetch_pc_i,
  output logic [DEC_W*ACE_PC_W-1:0]     pc_o
`endif
);

  localparam int PTR_W = instbuf_ptr_w(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int DEQ_W = $clog2(DEC_W + 1);
  localparam int ENQ_W = $clog2(FETCH_W + 1);

  logic [PTR_W-1:0]            head, head_next;
  logic [PTR_W-1:0]            tail, tail_next;
  logic [CNT_W-1:0]            count, count_next;
  logic [ACE_INST_W-1:0]       mem_inst [DEPTH];
  logic [FETCH_W*ACE_INST_W-1:0] cmp_inst;
  logic [ENQ_W-1:0]            enq_cnt;
  logic                        enq_ok;
  logic [DEQ_W-1:0]            avail;
  logic [DEQ_W-1:0]            eff_deq;
`ifdef ACE_INSTBUF_PC_EN
  logic [ACE_PC_W-1:0]         mem_pc [DEPTH];
  logic [FETCH_W*ACE_PC_W-1:0] cmp_pc;
`endif

  ace_instbuf_compact #(
    .FETCH_W (FETCH_W)
  ) u_compact (
    .fetch_inst_i (fetch_inst_i),
    .fetch_vld_i  (fetch_vld_i),
`ifdef ACE_INSTBUF_PC_EN
    .fetch_pc_i   (fetch_pc_i),
    .cmp_pc_o     (cmp_pc),
`endif
    .cmp_inst_o   (cmp_inst),
    .enq_cnt_o    (enq_cnt)
  );

  // Full looks only at the registered count, so a same-cycle dequeue never admits a group.
  assign instbuf_full_o  = (count > CNT_W'(DEPTH - FETCH_W));
  assign instbuf_empty_o = (count == '0);
  assign count_o         = count;
  assign enq_ok          = !flush_i && !instbuf_full_o && (|fetch_vld_i);

  // Decode can only take what is actually presented, so the request is clamped.
  always_comb begin
    avail   = (count >= CNT_W'(DEC_W)) ? DEQ_W'(DEC_W) : count[DEQ_W-1:0];
    eff_deq = (deq_cnt_i < avail) ? deq_cnt_i : avail;
  end

  always_comb begin
    head_next  = head;
    tail_next  = tail;
    count_next = count;
    if (flush_i) begin
      head_next  = '0;
      tail_next  = '0;
      count_next = '0;
    end else begin
      head_next  = head + PTR_W'(eff_deq);
      if (enq_ok) begin
        tail_next = tail + PTR_W'(enq_cnt);
      end
      count_next = count + CNT_W'(enq_ok ? enq_cnt : '0) - CNT_W'(eff_deq);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head_next;
      tail  <= tail_next;
      count <= count_next;
    end
  end

  // Entry storage is left unreset; stale entries are hidden by count.
  always_ff @(posedge clock) begin
    if (enq_ok) begin
      for (int j = 0; j < FETCH_W; j++) begin
        if (ENQ_W'(j) < enq_cnt) begin
          mem_inst[tail + PTR_W'(j)] <= cmp_inst[j*ACE_INST_W +: ACE_INST_W];
`ifdef ACE_INSTBUF_PC_EN
          mem_pc[tail + PTR_W'(j)]   <= cmp_pc[j*ACE_PC_W +: ACE_PC_W];
`endif
        end
      end
    end
  end

  always_comb begin
    inst_o     = '0;
    inst_vld_o = '0;
`ifdef ACE_INSTBUF_PC_EN
    pc_o       = '0;
`endif
    for (int i = 0; i < DEC_W; i++) begin
      if (CNT_W'(i) < count) begin
        inst_vld_o[i]                     = 1'b1;
        inst_o[i*ACE_INST_W +: ACE_INST_W] = mem_inst[head + PTR_W'(i)];
`ifdef ACE_INSTBUF_PC_EN
        pc_o[i*ACE_PC_W +: ACE_PC_W]       = mem_pc[head + PTR_W'(i)];
`endif
      end
    end
  end

endmodule

// File: tb/tb_ace_instbuf.sv
// Directed self-checking bench for ace_instbuf with FETCH_W=8, DEC_W=4, DEPTH=16.
// PC checks are compiled in when ACE_INSTBUF_PC_EN is defined.
module tb_ace_instbuf;

  logic         clock;
  logic         reset;
  logic         flush_i;
  logic [255:0] fetch_inst_i;
  logic [7:0]   fetch_vld_i;
  logic [2:0]   deq_cnt_i;
  logic [127:0] inst_o;
  logic [3:0]   inst_vld_o;
  logic [4:0]   count_o;
  logic         instbuf_full_o;
  logic         instbuf_empty_o;
`ifdef ACE_INSTBUF_PC_EN
  logic [63:0]  fetch_pc_i;
  logic [255:0] pc_o;
`endif

  int errors;
  int checks;

  ace_instbuf #(
    .FETCH_W (8),
    .DEC_W   (4),
    .DEPTH   (16)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .flush_i         (flush_i),
    .fetch_inst_i    (fetch_inst_i),
    .fetch_vld_i     (fetch_vld_i),
    .deq_cnt_i       (deq_cnt_i),
    .inst_o          (inst_o),
    .inst_vld_o      (inst_vld_o),
    .count_o         (count_o),
    .instbuf_full_o  (instbuf_full_o),
    .instbuf_empty_o (instbuf_empty_o)
`ifdef ACE_INSTBUF_PC_EN
    ,
    .fetch_pc_i      (fetch_pc_i),
    .pc_o            (pc_o)
`endif
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [255:0] actual, input logic [255:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // Drives one cycle of inputs (lane k carries base+k), then samples 1ns after the edge.
  task automatic applyStimulus(input logic [7:0] vld, input logic [31:0] base,
                               input logic [2:0] deq, input logic flush);
    fetch_vld_i = vld;
    for (int k = 0; k < 8; k++) begin
      fetch_inst_i[k*32 +: 32] = base + 32'(k);
    end
    deq_cnt_i = deq;
    flush_i   = flush;
    @(posedge clock);
    #1;
    fetch_vld_i = '0;
    deq_cnt_i   = '0;
    flush_i     = 1'b0;
  endtask

  initial begin
    errors       = 0;
    checks       = 0;
    clock        = 1'b0;
    reset        = 1'b0;
    flush_i      = 1'b0;
    fetch_inst_i = '0;
    fetch_vld_i  = '0;
    deq_cnt_i    = '0;
`ifdef ACE_INSTBUF_PC_EN
    fetch_pc_i   = 64'h1000;
`endif
    #1 reset = 1'b1;
    #2;
    checkOutput("rst_count", 256'(count_o), 256'(0));
    checkOutput("rst_empty", 256'(instbuf_empty_o), 256'(1));
    checkOutput("rst_full", 256'(instbuf_full_o), 256'(0));
    checkOutput("rst_vld", 256'(inst_vld_o), 256'(0));
    checkOutput("rst_inst", 256'(inst_o), 256'(0));
    @(posedge clock);
    #1 reset = 1'b0;

    // Full fetch group
    applyStimulus(8'hFF, 32'h0, 3'd0, 1'b0);
    checkOutput("t1_count", 256'(count_o), 256'(8));
    checkOutput("t1_vld", 256'(inst_vld_o), 256'(4'hF));
    checkOutput("t1_inst", 256'(inst_o), 256'({32'h3, 32'h2, 32'h1, 32'h0}));
    checkOutput("t1_empty", 256'(instbuf_empty_o), 256'(0));
    checkOutput("t1_full", 256'(instbuf_full_o), 256'(0));

    // Sparse group after a flush
    applyStimulus(8'h00, 32'h0, 3'd0, 1'b1);
    checkOutput("t2_flush_empty", 256'(instbuf_empty_o), 256'(1));
    applyStimulus(8'b1010_0101, 32'h0, 3'd0, 1'b0);
    checkOutput("t2_count", 256'(count_o), 256'(4));
    checkOutput("t2_inst", 256'(inst_o), 256'({32'h7, 32'h5, 32'h2, 32'h0}));
`ifdef ACE_INSTBUF_PC_EN
    checkOutput("t2_pc", pc_o, {64'h101C, 64'h1014, 64'h1008, 64'h1000});
`endif

    // Fill to 9, then a full-cycle enqueue is dropped while dequeue proceeds
    applyStimulus(8'h1F, 32'h100, 3'd0, 1'b0);
    checkOutput("t3_count9", 256'(count_o), 256'(9));
    checkOutput("t3_full", 256'(instbuf_full_o), 256'(1));
    applyStimulus(8'hFF, 32'h200, 3'd4, 1'b0);
    checkOutput("t3_count5", 256'(count_o), 256'(5));
    checkOutput("t3_notfull", 256'(instbuf_full_o), 256'(0));
    checkOutput("t3_inst", 256'(inst_o), 256'({32'h103, 32'h102, 32'h101, 32'h100}));

    // Over-request is clamped to what is presented
    applyStimulus(8'h00, 32'h0, 3'd4, 1'b0);
    checkOutput("t5_count1", 256'(count_o), 256'(1));
    checkOutput("t5_inst1", 256'(inst_o), 256'({32'h0, 32'h0, 32'h0, 32'h104}));
    applyStimulus(8'h01, 32'h300, 3'd0, 1'b0);
    checkOutput("t5_vld2", 256'(inst_vld_o), 256'(4'h3));
    applyStimulus(8'h00, 32'h0, 3'd4, 1'b0);
    checkOutput("t5_count0", 256'(count_o), 256'(0));
    checkOutput("t5_empty", 256'(instbuf_empty_o), 256'(1));
    checkOutput("t5_vld0", 256'(inst_vld_o), 256'(0));

    // Move head/tail to 12, then a group straddles the wrap
    applyStimulus(8'h03, 32'h400, 3'd0, 1'b0);
    applyStimulus(8'h00, 32'h0, 3'd2, 1'b0);
    checkOutput("t4_pre_count", 256'(count_o), 256'(0));
    applyStimulus(8'hFF, 32'h500, 3'd0, 1'b0);
    checkOutput("t4_count8", 256'(count_o), 256'(8));
    checkOutput("t4_inst0", 256'(inst_o), 256'({32'h503, 32'h502, 32'h501, 32'h500}));
    applyStimulus(8'h00, 32'h0, 3'd2, 1'b0);
    checkOutput("t4_inst1", 256'(inst_o), 256'({32'h505, 32'h504, 32'h503, 32'h502}));
    applyStimulus(8'h00, 32'h0, 3'd2, 1'b0);
    checkOutput("t4_inst2", 256'(inst_o), 256'({32'h507, 32'h506, 32'h505, 32'h504}));
    applyStimulus(8'h00, 32'h0, 3'd2, 1'b0);
    checkOutput("t4_inst3", 256'(inst_o), 256'({32'h0, 32'h0, 32'h507, 32'h506}));
    checkOutput("t4_vld3", 256'(inst_vld_o), 256'(4'h3));
    applyStimulus(8'h00, 32'h0, 3'd2, 1'b0);
    checkOutput("t4_empty", 256'(instbuf_empty_o), 256'(1));
    applyStimulus(8'h01, 32'h600, 3'd0, 1'b0);
    checkOutput("t4_tail", 256'(inst_o), 256'({32'h0, 32'h0, 32'h0, 32'h600}));

    // Reach count 10, then flush beats enqueue and dequeue
    applyStimulus(8'h01, 32'h610, 3'd0, 1'b0);
    applyStimulus(8'hFF, 32'h700, 3'd0, 1'b0);
    checkOutput("t6_count10", 256'(count_o), 256'(10));
    checkOutput("t6_full", 256'(instbuf_full_o), 256'(1));
    checkOutput("t6_inst", 256'(inst_o), 256'({32'h701, 32'h700, 32'h610, 32'h600}));
    applyStimulus(8'hFF, 32'h780, 3'd3, 1'b1);
    checkOutput("t6_count0", 256'(count_o), 256'(0));
    checkOutput("t6_empty", 256'(instbuf_empty_o), 256'(1));
    checkOutput("t6_notfull", 256'(instbuf_full_o), 256'(0));
    checkOutput("t6_vld0", 256'(inst_vld_o), 256'(0));
    applyStimulus(8'hFF, 32'h800, 3'd0, 1'b0);
    checkOutput("t6_refill", 256'(inst_o), 256'({32'h803, 32'h802, 32'h801, 32'h800}));

    // Asynchronous reset takes effect between clock edges
    reset = 1'b1;
    #2;
    checkOutput("arst_count", 256'(count_o), 256'(0));
    checkOutput("arst_empty", 256'(instbuf_empty_o), 256'(1));
    checkOutput("arst_vld", 256'(inst_vld_o), 256'(0));
    checkOutput("arst_inst", 256'(inst_o), 256'(0));
    @(posedge clock);
    #1 reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
